bs_rbtr_mode: RTL and testbench
===============================

BS_RBTR_MODE -- requirements
Module: bs_rbtr_mode

Interface
REQ-001 SHALL have parameter DRVRS, default 4, number of attached devices (2..16).
REQ-002 SHALL have parameter PCKG_SZ, default 16, packet width in bits (>=9).
REQ-003 SHALL have parameter BROADCAST, default {8{1'b1}}, destination ID meaning all devices.
REQ-004 SHALL have parameter MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port pndng, input, [DRVRS-1:0], device i holds at least one packet.
REQ-008 SHALL have port D_pop, input, [DRVRS-1:0][PCKG_SZ-1:0], head packet of device i; valid while pndng[i]=1.
REQ-009 SHALL have port pop, output, [DRVRS-1:0], one-cycle dequeue strobe to device i.
REQ-010 SHALL have port push, output, [DRVRS-1:0], one-cycle enqueue strobe to device i.
REQ-011 SHALL have port D_push, output, [DRVRS-1:0][PCKG_SZ-1:0], packet delivered to device i.
REQ-012 SHALL have port busy, output, 1, high when the FSM is not in IDLE.
REQ-013 SHALL have port drop_cnt, output, 8, count of dropped packets, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, DELIVER; all outputs registered.
REQ-015 In IDLE with pndng != 0, SHALL select grant index g per MODE, latch g, and move to GRANT next cycle.
REQ-016 In GRANT, if pndng[g]=1: pop[g]=1 for exactly one cycle, D_pop[g] captured, go to DELIVER; if pndng[g]=0: no pop, return to IDLE.
REQ-017 Destination field SHALL be captured packet bits [PCKG_SZ-1 -: 8].
REQ-018 In DELIVER: dest < DRVRS -> push[dest]=1; dest == BROADCAST -> push[i]=1 for every i != g; otherwise push=0 and drop_cnt increments; then return to IDLE.
REQ-019 D_push[i] SHALL carry the captured packet on every lane in the DELIVER cycle; 0 otherwise.
REQ-020 Dest == g (loopback) SHALL be delivered to device g normally.
REQ-021 In round-robin mode the priority pointer SHALL become g+1 (mod DRVRS) after each GRANT with pop, and stay unchanged on abort.
REQ-022 In round-robin mode the search SHALL start at the pointer and wrap past DRVRS-1 to 0.
REQ-023 Throughput SHALL be one packet per 3 cycles; pop-to-push latency SHALL be 1 cycle.
REQ-024 drop_cnt SHALL saturate at 255 and not wrap.
REQ-025 At most one pop bit SHALL be high in any cycle; pop and push SHALL never both be high in the same cycle.

Reset
REQ-026 reset=1 at a rising edge SHALL force FSM to IDLE, pointer to 0, and pop, push, D_push, busy and drop_cnt to 0 on that edge.
REQ-027 Reset asserted in GRANT or DELIVER SHALL abandon the packet with no pop or push in the following cycle.

Structure
REQ-028 Package bs_rbtr_pkg SHALL hold the state enum, ID_W=8, and the MODE_RR/MODE_FIXED constants.
REQ-029 Grant selection SHALL be the sub-module bs_rr_arbtr (inputs: request vector, pointer, mode; output: one-hot grant plus index).

Verification (DRVRS=4, PCKG_SZ=16, BROADCAST=8'hFF)
REQ-030 Device 0 sends 16'h02AB -> pop[0] 1 cycle, next cycle push=4'b0100, D_push[2]=16'h02AB.
REQ-031 Device 3 sends 16'hFF5A -> push=4'b0111 in one cycle, all lanes 16'hFF5A, push[3]=0.
REQ-032 All pndng=1 for 12 packets, MODE=0 -> grant order 0,1,2,3,0,1,...; MODE=1 -> always 0.
REQ-033 Packet 16'h0711 -> no push, drop_cnt 0->1; 300 such packets -> drop_cnt=255.
REQ-034 pndng[1] drops during GRANT -> no pop, FSM back to IDLE, pointer unchanged.
REQ-035 reset asserted in the DELIVER cycle -> no push on the next edge, all outputs 0, busy=0.

Source files
------------

// File: rtl/bs_rbtr_pkg.sv
// Shared types and constants for the bs_rbtr_mode packet arbiter/router.
package bs_rbtr_pkg;

    localparam int         ID_W       = 8;
    localparam logic       MODE_RR    = 1'b0;
    localparam logic       MODE_FIXED = 1'b1;
    localparam logic [7:0] CNT_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DELIVER = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == CNT_MAX) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/bs_rr_arbtr.sv
// Grant selector: round-robin search from a pointer with wrap, or fixed
// lowest-index priority. Purely combinational.
module bs_rr_arbtr
    import bs_rbtr_pkg::*;
#(
    parameter int DRVRS = 4,
    parameter int IDX_W = 2
) (
    input  logic [DRVRS-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [DRVRS-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    // First requester found from the start position wins.
    always_comb begin
        logic             found_s;
        logic             hit_s;
        logic [IDX_W-1:0] cand_s;
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = {IDX_W{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        for (int k = 0; k < DRVRS; k++) begin
            cand_s  = (mode_i == MODE_FIXED) ? IDX_W'(k)
                                             : IDX_W'((int'(ptr_i) + k) % DRVRS);
            hit_s   = ~found_s & req_i[cand_s];
            idx_o   = hit_s ? cand_s : idx_o;
            found_s = found_s | hit_s;
        end
        gnt_o = found_s ? ({{(DRVRS-1){1'b0}}, 1'b1} << idx_o) : {DRVRS{1'b0}};
    end

endmodule

// File: rtl/bs_rbtr_mode.sv
// Bus arbiter/router: grants one pending device, pops its head packet and
// delivers it by destination ID (unicast, broadcast or drop).
module bs_rbtr_mode
    import bs_rbtr_pkg::*;
#(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter logic [ID_W-1:0] BROADCAST = {8{1'b1}},
    parameter int              MODE      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DRVRS-1:0]              pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]              pop,
    output logic [DRVRS-1:0]              push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0] D_push,
    output logic                          busy,
    output logic [7:0]                    drop_cnt
);

    localparam int              IDX_W    = $clog2(DRVRS);
    localparam logic [ID_W-1:0] DRVRS_ID = ID_W'(DRVRS);
    localparam logic            MODE_SEL = (MODE == 1) ? MODE_FIXED : MODE_RR;

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [IDX_W-1:0]              g_q, g_d;
    logic [PCKG_SZ-1:0]            pkt_q, pkt_d;
    logic [DRVRS-1:0]              pop_q, pop_d;
    logic [DRVRS-1:0]              push_q, push_d;
    logic [DRVRS-1:0][PCKG_SZ-1:0] dpush_q, dpush_d;
    logic                          busy_q, busy_d;
    logic [7:0]                    drop_q, drop_d;
    logic [DRVRS-1:0]              arb_gnt_s;
    logic [IDX_W-1:0]              arb_idx_s;
    logic [ID_W-1:0]               dest_s;

    assign dest_s = pkt_q[PCKG_SZ-1 -: ID_W];

    bs_rr_arbtr #(
        .DRVRS (DRVRS),
        .IDX_W (IDX_W)
    ) u_arbtr (
        .req_i  (pndng),
        .ptr_i  (ptr_q),
        .mode_i (MODE_SEL),
        .gnt_o  (arb_gnt_s),
        .idx_o  (arb_idx_s)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= {IDX_W{1'b0}};
            g_q     <= {IDX_W{1'b0}};
            pkt_q   <= {PCKG_SZ{1'b0}};
            pop_q   <= {DRVRS{1'b0}};
            push_q  <= {DRVRS{1'b0}};
            dpush_q <= {(DRVRS*PCKG_SZ){1'b0}};
            busy_q  <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            pkt_q   <= pkt_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            dpush_q <= dpush_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic; pointer only advances on a real pop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        pkt_d   = pkt_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt_s) begin
                    state_d = ST_GRANT;
                    g_d     = arb_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (pndng[g_q]) begin
                    state_d = ST_DELIVER;
                    pkt_d   = D_pop[g_q];
                    if (MODE_SEL == MODE_RR) begin
                        ptr_d = (g_q == IDX_W'(DRVRS - 1)) ? {IDX_W{1'b0}} : (g_q + IDX_W'(1));
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELIVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered strobes, data lanes and counters.
    always_comb begin
        pop_d   = {DRVRS{1'b0}};
        push_d  = {DRVRS{1'b0}};
        dpush_d = {(DRVRS*PCKG_SZ){1'b0}};
        drop_d  = drop_q;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_GRANT: begin
                if (pndng[g_q]) begin
                    pop_d[g_q] = 1'b1;
                end else begin
                    pop_d = {DRVRS{1'b0}};
                end
            end
            ST_DELIVER: begin
                dpush_d = {DRVRS{pkt_q}};
                if (dest_s < DRVRS_ID) begin
                    push_d[dest_s[IDX_W-1:0]] = 1'b1;
                end else if (dest_s == BROADCAST) begin
                    push_d = ~({{(DRVRS-1){1'b0}}, 1'b1} << g_q);
                end else begin
                    drop_d = sat_inc8(drop_q);
                end
            end
            default: begin
                pop_d = {DRVRS{1'b0}};
            end
        endcase
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = dpush_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bs_rbtr_mode.sv
// Randomized + directed self-checking bench for bs_rbtr_mode (4 devices, 16-bit packets).
module tb_bs_rbtr_mode;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        pndng_rr, pop_rr, push_rr;
    logic [N-1:0][W-1:0] dpop_rr, dpush_rr;
    logic                busy_rr;
    logic [7:0]          drop_rr;
    logic [N-1:0]        pndng_fx, pop_fx, push_fx;
    logic [N-1:0][W-1:0] dpop_fx, dpush_fx;
    logic                busy_fx;
    logic [7:0]          drop_fx;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ptr  = 0;
    int m_drop = 0;

    always #5 clk = ~clk;

    bs_rbtr_mode #(.DRVRS(N), .PCKG_SZ(W), .BROADCAST(8'hFF), .MODE(0)) dut_rr (
        .clk(clk), .reset(reset), .pndng(pndng_rr), .D_pop(dpop_rr), .pop(pop_rr),
        .push(push_rr), .D_push(dpush_rr), .busy(busy_rr), .drop_cnt(drop_rr));

    bs_rbtr_mode #(.DRVRS(N), .PCKG_SZ(W), .BROADCAST(8'hFF), .MODE(1)) dut_fx (
        .clk(clk), .reset(reset), .pndng(pndng_fx), .D_pop(dpop_fx), .pop(pop_fx),
        .push(push_fx), .D_push(dpush_fx), .busy(busy_fx), .drop_cnt(drop_fx));

    // Reference: which device should win, searching from ptr (mode 0) or from 0 (mode 1).
    function automatic int m_grant(input logic [N-1:0] pend, input int ptr, input int mode);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mode == 1) ? k : (ptr + k) % N;
            if (pend[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Reference: which devices receive a packet with this destination from sender g.
    function automatic logic [N-1:0] m_push(input logic [7:0] dest, input int g);
        logic [N-1:0] v;
        v = '0;
        if (dest < 8'(N)) v[dest[1:0]] = 1'b1;
        else if (dest == 8'hFF) begin
            for (int i = 0; i < N; i++) v[i] = (i != g);
        end
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pndng_rr = '0; pndng_fx = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0; m_drop = 0;
    endtask

    // Raise pend, wait (bounded) for the pop, drop pend, capture the following cycle.
    task automatic xfer(input logic [N-1:0] pend, output logic [N-1:0] pop_v, output logic [N-1:0] pop2_v,
                        output logic [N-1:0] push_v, output logic [N-1:0][W-1:0] dp_v,
                        output logic [7:0] drop_v, output bit timed_out);
        timed_out = 1'b1;
        pndng_rr = pend;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pop_rr != '0) begin
                timed_out = 1'b0;
                break;
            end
        end
        pop_v = pop_rr;
        pndng_rr = '0;
        @(negedge clk);
        pop2_v = pop_rr; push_v = push_rr; dp_v = dpush_rr; drop_v = drop_rr;
    endtask

    task automatic test_reset();
        reset = 1'b1; pndng_rr = '0; pndng_fx = '0; dpop_rr = '0; dpop_fx = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (pop_rr !== 4'b0)   begin n_fail++; $display("FAIL reset_pop: got %b expected 0000", pop_rr); end
        n_cmp++; if (push_rr !== 4'b0)  begin n_fail++; $display("FAIL reset_push: got %b expected 0000", push_rr); end
        n_cmp++; if (dpush_rr !== 64'h0) begin n_fail++; $display("FAIL reset_dpush: got %h expected 0", dpush_rr); end
        n_cmp++; if (busy_rr !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_rr); end
        n_cmp++; if (drop_rr !== 8'd0)  begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_rr); end
        n_cmp++; if (busy_fx !== 1'b0 || pop_fx !== 4'b0) begin n_fail++; $display("FAIL reset_fx: got busy %b pop %b expected 0", busy_fx, pop_fx); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_rr !== 1'b0)  begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy_rr); end
    endtask

    task automatic test_unicast();
        do_reset();
        dpop_rr[0] = 16'h02AB;
        pndng_rr = 4'b0001;
        @(negedge clk);
        n_cmp++; if (pop_rr !== 4'b0000 || busy_rr !== 1'b1) begin n_fail++; $display("FAIL uni_grant: got pop %b busy %b expected 0000/1", pop_rr, busy_rr); end
        @(negedge clk);
        n_cmp++; if (pop_rr !== 4'b0001) begin n_fail++; $display("FAIL uni_pop: got %b expected 0001", pop_rr); end
        n_cmp++; if (push_rr !== 4'b0000) begin n_fail++; $display("FAIL uni_push_early: got %b expected 0000", push_rr); end
        pndng_rr = 4'b0000;
        @(negedge clk);
        n_cmp++; if (pop_rr !== 4'b0000) begin n_fail++; $display("FAIL uni_pop_len: got %b expected 0000", pop_rr); end
        n_cmp++; if (push_rr !== 4'b0100) begin n_fail++; $display("FAIL uni_push: got %b expected 0100", push_rr); end
        n_cmp++; if (dpush_rr[2] !== 16'h02AB) begin n_fail++; $display("FAIL uni_data: got %h expected 02ab", dpush_rr[2]); end
        n_cmp++; if (busy_rr !== 1'b0) begin n_fail++; $display("FAIL uni_busy_end: got %b expected 0", busy_rr); end
        @(negedge clk);
        n_cmp++; if (push_rr !== 4'b0000 || dpush_rr !== 64'h0) begin n_fail++; $display("FAIL uni_after: got push %b data %h expected 0", push_rr, dpush_rr); end
        m_ptr = 1;
    endtask

    task automatic test_broadcast_loopback();
        logic [N-1:0] p1, p2, pu; logic [N-1:0][W-1:0] dv; logic [7:0] dr; bit to;
        dpop_rr[3] = 16'hFF5A;
        xfer(4'b1000, p1, p2, pu, dv, dr, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL bcast_timeout: got no pop expected pop within 8 cycles"); end
        n_cmp++; if (p1 !== 4'b1000) begin n_fail++; $display("FAIL bcast_pop: got %b expected 1000", p1); end
        n_cmp++; if (pu !== 4'b0111) begin n_fail++; $display("FAIL bcast_push: got %b expected 0111", pu); end
        n_cmp++; if (dv !== {N{16'hFF5A}}) begin n_fail++; $display("FAIL bcast_data: got %h expected all ff5a", dv); end
        m_ptr = 0;
        dpop_rr[2] = 16'h0233;
        xfer(4'b0100, p1, p2, pu, dv, dr, to);
        n_cmp++; if (to || pu !== 4'b0100) begin n_fail++; $display("FAIL loopback_push: got %b (timeout %0d) expected 0100", pu, to); end
        n_cmp++; if (dv[2] !== 16'h0233) begin n_fail++; $display("FAIL loopback_data: got %h expected 0233", dv[2]); end
        m_ptr = 3;
    endtask

    task automatic test_rr_order();
        int got; int last; int g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            dpop_rr[i] = {8'((i + 1) % N), 8'(8'hA0 + i)};
            dpop_fx[i] = dpop_rr[i];
        end
        pndng_rr = 4'hF; pndng_fx = 4'hF;
        got = 0; last = -1;
        for (int c = 0; c < 60 && got < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if (!$onehot0(pop_rr) || ((pop_rr != '0) && (push_rr != '0))) begin
                n_fail++; $display("FAIL rr_strobe_excl: got pop %b push %b expected one-hot pop, never with push", pop_rr, push_rr);
            end
            if (pop_fx != '0) begin
                n_cmp++; if (pop_fx !== 4'b0001) begin n_fail++; $display("FAIL fixed_grant: got %b expected 0001", pop_fx); end
            end
            if (pop_rr != '0) begin
                g = m_grant(4'hF, m_ptr, 0);
                n_cmp++; if (pop_rr !== (4'b0001 << g)) begin n_fail++; $display("FAIL rr_grant: got %b expected device %0d", pop_rr, g); end
                if (last >= 0) begin
                    n_cmp++; if (c - last != 3) begin n_fail++; $display("FAIL rr_spacing: got %0d cycles expected 3", c - last); end
                end
                last = c; got++;
                m_ptr = (g + 1) % N;
            end
        end
        pndng_rr = '0; pndng_fx = '0;
        n_cmp++; if (got != 12) begin n_fail++; $display("FAIL rr_count: got %0d pops expected 12", got); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [N-1:0] p1, p2, pu; logic [N-1:0][W-1:0] dv; logic [7:0] dr; bit to; int g;
        do_reset();
        dpop_rr[0] = 16'h0300;
        xfer(4'b0001, p1, p2, pu, dv, dr, to);
        m_ptr = 1;
        pndng_rr = 4'b0100;
        @(negedge clk);
        n_cmp++; if (busy_rr !== 1'b1) begin n_fail++; $display("FAIL abort_busy_grant: got %b expected 1", busy_rr); end
        pndng_rr = 4'b0000;
        @(negedge clk);
        n_cmp++; if (pop_rr !== 4'b0000 || busy_rr !== 1'b0) begin n_fail++; $display("FAIL abort_nopop: got pop %b busy %b expected 0000/0", pop_rr, busy_rr); end
        @(negedge clk);
        n_cmp++; if (push_rr !== 4'b0000) begin n_fail++; $display("FAIL abort_nopush: got %b expected 0000", push_rr); end
        dpop_rr[1] = 16'h0011;
        dpop_rr[0] = 16'h0022;
        g = m_grant(4'b0011, m_ptr, 0);
        xfer(4'b0011, p1, p2, pu, dv, dr, to);
        n_cmp++; if (to || p1 !== (4'b0001 << g)) begin n_fail++; $display("FAIL abort_ptr_kept: got pop %b expected device %0d", p1, g); end
        m_ptr = (g + 1) % N;
    endtask

    task automatic test_drop();
        logic [N-1:0] p1, p2, pu; logic [N-1:0][W-1:0] dv; logic [7:0] dr; bit to; int pops;
        do_reset();
        dpop_rr[1] = 16'h0711;
        xfer(4'b0010, p1, p2, pu, dv, dr, to);
        n_cmp++; if (to || p1 !== 4'b0010) begin n_fail++; $display("FAIL drop_pop: got %b expected 0010", p1); end
        n_cmp++; if (pu !== 4'b0000) begin n_fail++; $display("FAIL drop_push: got %b expected 0000", pu); end
        n_cmp++; if (dr !== 8'd1) begin n_fail++; $display("FAIL drop_cnt1: got %0d expected 1", dr); end
        pops = 1;
        pndng_rr = 4'b0010;
        for (int c = 0; c < 1500 && pops < 300; c++) begin
            @(negedge clk);
            if (pop_rr != '0) pops++;
        end
        pndng_rr = '0;
        repeat (4) @(negedge clk);
        n_cmp++; if (pops != 300) begin n_fail++; $display("FAIL drop_pops: got %0d expected 300", pops); end
        n_cmp++; if (drop_rr !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d expected 255", drop_rr); end
        m_ptr = 2; m_drop = 255;
    endtask

    task automatic test_reset_in_deliver();
        logic [N-1:0] p1, p2, pu; logic [N-1:0][W-1:0] dv; logic [7:0] dr; bit to; bit seen;
        do_reset();
        dpop_rr[0] = 16'h0933;
        xfer(4'b0001, p1, p2, pu, dv, dr, to);
        n_cmp++; if (to || dr !== 8'd1) begin n_fail++; $display("FAIL rstd_predrop: got %0d expected 1", dr); end
        dpop_rr[3] = 16'h0122;
        pndng_rr = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = (pop_rr != '0);
        end
        pndng_rr = '0;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstd_timeout: got no pop expected pop within 8 cycles"); end
        n_cmp++; if (push_rr !== 4'b0 || pop_rr !== 4'b0) begin n_fail++; $display("FAIL rstd_strobes: got push %b pop %b expected 0", push_rr, pop_rr); end
        n_cmp++; if (dpush_rr !== 64'h0 || busy_rr !== 1'b0 || drop_rr !== 8'd0) begin n_fail++; $display("FAIL rstd_outs: got data %h busy %b drop %0d expected 0", dpush_rr, busy_rr, drop_rr); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (push_rr !== 4'b0 || busy_rr !== 1'b0) begin n_fail++; $display("FAIL rstd_after: got push %b busy %b expected 0", push_rr, busy_rr); end
        m_ptr = 0; m_drop = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] pend, p1, p2, pu, ep; logic [N-1:0][W-1:0] dv; logic [7:0] dr, dest; logic [W-1:0] pkt;
        bit to; int g; int sel;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                sel = $urandom_range(0, 5);
                if (sel < 4) dest = 8'(sel);
                else if (sel == 4) dest = 8'hFF;
                else dest = 8'($urandom_range(4, 254));
                dpop_rr[i] = {dest, 8'($urandom)};
            end
            g = m_grant(pend, m_ptr, 0);
            pkt = dpop_rr[g[1:0]];
            ep = m_push(pkt[15:8], g);
            if (ep == '0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            xfer(pend, p1, p2, pu, dv, dr, to);
            n_cmp++; if (to || p1 !== (4'b0001 << g)) begin n_fail++; $display("FAIL rand_pop[%0d]: got %b expected device %0d", it, p1, g); end
            n_cmp++; if (p2 !== 4'b0 || pu !== ep) begin n_fail++; $display("FAIL rand_push[%0d]: got pop %b push %b expected 0000/%b", it, p2, pu, ep); end
            n_cmp++; if (dv !== {N{pkt}}) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected all %h", it, dv, pkt); end
            n_cmp++; if (dr !== 8'(m_drop)) begin n_fail++; $display("FAIL rand_drop[%0d]: got %0d expected %0d", it, dr, m_drop); end
            m_ptr = (g + 1) % N;
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast_loopback();
        test_rr_order();
        test_abort();
        test_drop();
        test_reset_in_deliver();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
